// File: rtl/key_event_gen_pkg.sv
// ---------------------------------------------------------------------------
// key_event_gen_pkg
// Purpose : Shared definitions for the push-button event generator.
//           - Default values for the sample divider, the debounce length and
//             the long-press length.
//           - Per-channel FSM state encoding.
//           - Helper that sizes a counter from the largest value it must hold.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package key_event_gen_pkg;

    localparam int DEF_SAMPLE_DIV   = 250000;  // 5 ms sample period at 50 MHz
    localparam int DEF_STABLE_COUNT = 4;       // agreeing samples per level change
    localparam int DEF_LONG_COUNT   = 200;     // held samples before a long press

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HELD        = 3'd2,
        LONG_HELD   = 3'd3,
        DEB_RELEASE = 3'd4
    } key_state_e;

    // Bits needed to represent 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_event_gen_channel.sv
// ---------------------------------------------------------------------------
// key_event_channel
// Purpose : One push-button channel: two-flop synchronizer, debounce FSM,
//           hold counter and registered event pulses.
// Ports   : i_clk      system clock
//           i_rst_n    asynchronous active-low reset
//           i_tick     one-cycle sample strobe shared by all channels
//           i_key      raw key level (asynchronous, 1 = pressed)
//           o_level    debounced level
//           o_press    one-cycle pulse on accepted press
//           o_release  one-cycle pulse on accepted release
//           o_long     one-cycle pulse once per press after the long hold
// ---------------------------------------------------------------------------
module key_event_channel
    import key_event_gen_pkg::*;
#(
    parameter int STABLE_COUNT = DEF_STABLE_COUNT,
    parameter int LONG_COUNT   = DEF_LONG_COUNT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int                 DEB_W     = cnt_width(STABLE_COUNT);
    localparam int                 HOLD_W    = cnt_width(LONG_COUNT);
    localparam logic [DEB_W-1:0]   DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]   DEB_DONE  = DEB_W'(STABLE_COUNT);
    localparam logic [HOLD_W-1:0]  HOLD_DONE = HOLD_W'(LONG_COUNT);

    logic              r_key_meta, r_key_sync;
    key_state_e        r_state, w_state_next;
    logic [DEB_W-1:0]  r_deb_cnt, w_deb_next, w_deb_inc;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_next, w_hold_inc;
    logic              r_long_done, w_long_done_next;
    logic              r_level, w_level_next;
    logic              r_press, w_press_next;
    logic              r_release, w_release_next;
    logic              r_long, w_long_next;
    logic              w_accept_press, w_start_release, w_finish_release;

    assign w_deb_inc  = r_deb_cnt + DEB_ONE;
    // Hold counter saturates at the long-press threshold so it can never wrap.
    assign w_hold_inc = (r_hold_cnt >= HOLD_DONE) ? r_hold_cnt : r_hold_cnt + 1'b1;

    always_comb begin
        w_state_next     = r_state;
        w_deb_next       = r_deb_cnt;
        w_hold_next      = r_hold_cnt;
        w_long_done_next = r_long_done;
        w_level_next     = r_level;
        w_press_next     = 1'b0;
        w_release_next   = 1'b0;
        w_long_next      = 1'b0;
        w_accept_press   = 1'b0;
        w_start_release  = 1'b0;
        w_finish_release = 1'b0;

        if (i_tick) begin
            case (r_state)
                IDLE: begin
                    if (r_key_sync) begin
                        if (STABLE_COUNT <= 1) begin
                            w_accept_press = 1'b1;
                        end else begin
                            w_state_next = DEB_PRESS;
                            w_deb_next   = DEB_ONE;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (!r_key_sync) begin
                        w_state_next = IDLE;
                        w_deb_next   = '0;
                    end else if (w_deb_inc == DEB_DONE) begin
                        w_accept_press = 1'b1;
                    end else begin
                        w_deb_next = w_deb_inc;
                    end
                end
                HELD: begin
                    w_hold_next = w_hold_inc;
                    if (!r_key_sync) begin
                        w_start_release = 1'b1;
                    end else if (w_hold_inc >= HOLD_DONE) begin
                        w_state_next     = LONG_HELD;
                        w_long_next      = 1'b1;
                        w_long_done_next = 1'b1;
                    end
                end
                LONG_HELD: begin
                    w_hold_next = w_hold_inc;
                    if (!r_key_sync) begin
                        w_start_release = 1'b1;
                    end
                end
                DEB_RELEASE: begin
                    // Hold time keeps running through a release glitch so the
                    // long-press point stays anchored to the original press.
                    w_hold_next = w_hold_inc;
                    if (r_key_sync) begin
                        w_deb_next = '0;
                        if (r_long_done) begin
                            w_state_next = LONG_HELD;
                        end else if (w_hold_inc >= HOLD_DONE) begin
                            w_state_next     = LONG_HELD;
                            w_long_next      = 1'b1;
                            w_long_done_next = 1'b1;
                        end else begin
                            w_state_next = HELD;
                        end
                    end else if (w_deb_inc == DEB_DONE) begin
                        w_finish_release = 1'b1;
                    end else begin
                        w_deb_next = w_deb_inc;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end

        if (w_accept_press) begin
            w_state_next = HELD;
            w_level_next = 1'b1;
            w_press_next = 1'b1;
            w_deb_next   = '0;
            w_hold_next  = '0;
        end

        if (w_start_release) begin
            if (STABLE_COUNT <= 1) begin
                w_finish_release = 1'b1;
            end else begin
                w_state_next = DEB_RELEASE;
                w_deb_next   = DEB_ONE;
            end
        end

        if (w_finish_release) begin
            w_state_next     = IDLE;
            w_level_next     = 1'b0;
            w_release_next   = 1'b1;
            w_deb_next       = '0;
            w_hold_next      = '0;
            w_long_done_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key_meta  <= 1'b0;
            r_key_sync  <= 1'b0;
            r_state     <= IDLE;
            r_deb_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_key_meta  <= i_key;
            r_key_sync  <= r_key_meta;
            r_state     <= w_state_next;
            r_deb_cnt   <= w_deb_next;
            r_hold_cnt  <= w_hold_next;
            r_long_done <= w_long_done_next;
            r_level     <= w_level_next;
            r_press     <= w_press_next;
            r_release   <= w_release_next;
            r_long      <= w_long_next;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/key_event_gen.sv
// ---------------------------------------------------------------------------
// key_event_gen
// Purpose : Two-channel push-button debouncer / event generator. A shared
//           divider produces the sample tick; each key bit has its own
//           key_event_channel.
// Ports   : Sys_CLK      system clock
//           Sys_RST      asynchronous active-low reset
//           Key[1:0]     raw key levels, 1 = pressed
//           Key_Level    debounced levels
//           Key_Press    one-cycle press pulses
//           Key_Release  one-cycle release pulses
//           Key_Long     one-cycle long-press pulses
// ---------------------------------------------------------------------------
module key_event_gen
    import key_event_gen_pkg::*;
#(
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int STABLE_COUNT = DEF_STABLE_COUNT,
    parameter int LONG_COUNT   = DEF_LONG_COUNT
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST,
    input  logic [1:0] Key,
    output logic [1:0] Key_Level,
    output logic [1:0] Key_Press,
    output logic [1:0] Key_Release,
    output logic [1:0] Key_Long
);

    localparam int                TICK_W    = cnt_width(SAMPLE_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);

    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            key_event_channel #(
                .STABLE_COUNT (STABLE_COUNT),
                .LONG_COUNT   (LONG_COUNT)
            ) u_chan (
                .i_clk     (Sys_CLK),
                .i_rst_n   (Sys_RST),
                .i_tick    (w_tick),
                .i_key     (Key[gi]),
                .o_level   (Key_Level[gi]),
                .o_press   (Key_Press[gi]),
                .o_release (Key_Release[gi]),
                .o_long    (Key_Long[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_event_gen.sv
// ---------------------------------------------------------------------------
// tb_key_event_gen
// Purpose : Scoreboard bench for key_event_gen (SAMPLE_DIV=10, STABLE_COUNT=4,
//           LONG_COUNT=20). Stimulus pushes expected events; a monitor pops
//           and compares whenever an event pulse appears.
// ---------------------------------------------------------------------------
module tb_key_event_gen;

    localparam int SDIV     = 10;
    localparam int STAB     = 4;
    localparam int LONGC    = 20;
    localparam int LAT      = 2 + STAB * SDIV;   // 42-cycle press/release bound
    localparam int LONG_DLY = LONGC * SDIV;      // 200 cycles press -> long

    logic       Sys_CLK = 1'b0;
    logic       Sys_RST = 1'b0;
    logic [1:0] Key     = 2'b00;
    logic [1:0] Key_Level, Key_Press, Key_Release, Key_Long;

    key_event_gen #(
        .SAMPLE_DIV   (SDIV),
        .STABLE_COUNT (STAB),
        .LONG_COUNT   (LONGC)
    ) dut (
        .Sys_CLK     (Sys_CLK),
        .Sys_RST     (Sys_RST),
        .Key         (Key),
        .Key_Level   (Key_Level),
        .Key_Press   (Key_Press),
        .Key_Release (Key_Release),
        .Key_Long    (Key_Long)
    );

    always #5 Sys_CLK = ~Sys_CLK;

    typedef struct {
        int         tag;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lng;
        int         min_cyc;
        int         max_cyc;
        bit         after_press;   // check distance from last press instead of window
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_press[2];
    int   mon_ch;
    int   c0;
    int   r0;

    always @(posedge Sys_CLK) cyc <= cyc + 1;

    // Monitor: one pop per cycle that shows any event pulse.
    always @(negedge Sys_CLK) begin
        if (Sys_RST && ((Key_Press | Key_Release | Key_Long) != 2'b00)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d got press=%b release=%b long=%b required no event",
                         cyc, Key_Press, Key_Release, Key_Long);
            end else begin
                mon_e = exp_q.pop_front();
                n_cmp++;
                if (Key_Press !== mon_e.press || Key_Release !== mon_e.rel || Key_Long !== mon_e.lng) begin
                    n_bad++;
                    $display("FAIL ev%0d_kind cyc=%0d got p/r/l=%b/%b/%b required %b/%b/%b",
                             mon_e.tag, cyc, Key_Press, Key_Release, Key_Long,
                             mon_e.press, mon_e.rel, mon_e.lng);
                end
                n_cmp++;
                if (mon_e.after_press) begin
                    mon_ch = mon_e.lng[1] ? 1 : 0;
                    if (cyc - last_press[mon_ch] != LONG_DLY) begin
                        n_bad++;
                        $display("FAIL ev%0d_long_delay got=%0d required=%0d",
                                 mon_e.tag, cyc - last_press[mon_ch], LONG_DLY);
                    end
                end else if (cyc < mon_e.min_cyc || cyc > mon_e.max_cyc) begin
                    n_bad++;
                    $display("FAIL ev%0d_timing got cyc=%0d required %0d..%0d",
                             mon_e.tag, cyc, mon_e.min_cyc, mon_e.max_cyc);
                end
                $display("ev%0d cyc=%0d press=%b release=%b long=%b",
                         mon_e.tag, cyc, Key_Press, Key_Release, Key_Long);
            end
            if (Key_Press[0]) last_press[0] = cyc;
            if (Key_Press[1]) last_press[1] = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Sys_CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s got=%b required=%b", name, act, req);
        end
    endtask

    task automatic expect_ev(input int tag, input logic [1:0] p, input logic [1:0] r,
                             input logic [1:0] l, input int lo, input int hi, input bit rel);
        exp_t e;
        e.tag = tag; e.press = p; e.rel = r; e.lng = l;
        e.min_cyc = lo; e.max_cyc = hi; e.after_press = rel;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout got pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got time limit reached required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        last_press[0] = 0;
        last_press[1] = 0;

        // Reset state
        step(3);
        check("rst_level",   Key_Level,   2'b00);
        check("rst_press",   Key_Press,   2'b00);
        check("rst_release", Key_Release, 2'b00);
        check("rst_long",    Key_Long,    2'b00);
        Sys_RST = 1'b1;
        step(5);

        // Key[0] held 100 cycles: one press, no long, then release
        c0 = cyc; Key[0] = 1'b1;
        expect_ev(1, 2'b01, 2'b00, 2'b00, c0 + 1, c0 + LAT, 1'b0);
        step(100);
        check("t1_level_held", Key_Level, 2'b01);
        drain("t1_press", 1);
        c0 = cyc; Key[0] = 1'b0;
        expect_ev(2, 2'b00, 2'b01, 2'b00, c0 + 1, c0 + LAT, 1'b0);
        drain("t1_release", 60);
        step(5);
        check("t1_level_off", Key_Level, 2'b00);

        // 25-cycle pulses with 25-cycle gaps: never debounced
        for (int i = 0; i < 4; i++) begin
            Key[0] = 1'b1;
            step(25);
            check("t2_level_pulse", Key_Level, 2'b00);
            Key[0] = 1'b0;
            step(25);
        end
        check("t2_level_end", Key_Level, 2'b00);

        // Key[1] held 300 cycles: press, long exactly 200 cycles later, release
        c0 = cyc; Key[1] = 1'b1;
        expect_ev(3, 2'b10, 2'b00, 2'b00, c0 + 1, c0 + LAT, 1'b0);
        expect_ev(4, 2'b00, 2'b00, 2'b10, 0, 0, 1'b1);
        step(300);
        check("t3_level_held", Key_Level, 2'b10);
        drain("t3_long", 1);
        c0 = cyc; Key[1] = 1'b0;
        expect_ev(5, 2'b00, 2'b10, 2'b00, c0 + 1, c0 + LAT, 1'b0);
        drain("t3_release", 60);
        check("t3_level_off", Key_Level, 2'b00);

        // Both keys in the same cycle
        c0 = cyc; Key = 2'b11;
        expect_ev(6, 2'b11, 2'b00, 2'b00, c0 + 1, c0 + LAT, 1'b0);
        step(80);
        check("t4_level_both", Key_Level, 2'b11);
        drain("t4_press", 1);
        c0 = cyc; Key = 2'b00;
        expect_ev(7, 2'b00, 2'b11, 2'b00, c0 + 1, c0 + LAT, 1'b0);
        drain("t4_release", 60);
        check("t4_level_off", Key_Level, 2'b00);

        // Reset mid-hold with Key[0] still pressed
        c0 = cyc; Key[0] = 1'b1;
        expect_ev(8, 2'b01, 2'b00, 2'b00, c0 + 1, c0 + LAT, 1'b0);
        step(100);
        check("t5_level_before", Key_Level, 2'b01);
        drain("t5_press", 1);
        #2;
        Sys_RST = 1'b0;
        #1;
        check("t5_rst_level",   Key_Level,   2'b00);
        check("t5_rst_press",   Key_Press,   2'b00);
        check("t5_rst_release", Key_Release, 2'b00);
        check("t5_rst_long",    Key_Long,    2'b00);
        step(4);
        Sys_RST = 1'b1;
        r0 = cyc;
        // Tick counter restarts at 0: ticks land on r0+10k, fourth sample at r0+40.
        expect_ev(9, 2'b01, 2'b00, 2'b00, r0 + 40, r0 + 40, 1'b0);
        step(60);
        check("t5_level_fresh", Key_Level, 2'b01);
        drain("t5_fresh_press", 1);
        c0 = cyc; Key[0] = 1'b0;
        expect_ev(10, 2'b00, 2'b01, 2'b00, c0 + 1, c0 + LAT, 1'b0);
        drain("t5_release", 60);
        check("t5_level_off", Key_Level, 2'b00);

        // Two-tick 0-glitch during HELD with a known tick phase
        Sys_RST = 1'b0;
        step(3);
        Sys_RST = 1'b1;
        r0 = cyc;
        Key[0] = 1'b1;
        expect_ev(11, 2'b01, 2'b00, 2'b00, r0 + 40,  r0 + 40,  1'b0);
        expect_ev(12, 2'b00, 2'b00, 2'b01, r0 + 240, r0 + 240, 1'b0);
        step(75);
        Key[0] = 1'b0;            // synchronized 0 seen by ticks at r0+80 and r0+90
        step(20);
        check("t6_level_glitch", Key_Level, 2'b01);
        Key[0] = 1'b1;            // tick at r0+100 sees 1 again
        step(205);
        check("t6_level_long", Key_Level, 2'b01);
        drain("t6_long", 1);
        Key[0] = 1'b0;            // cyc == r0+300; release on the tick at r0+340
        expect_ev(13, 2'b00, 2'b01, 2'b00, r0 + 340, r0 + 340, 1'b0);
        drain("t6_release", 60);
        check("t6_level_off", Key_Level, 2'b00);

        step(30);
        drain("final", 1);
        check("final_level", Key_Level, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
